rxll_frame_fifo: RTL and testbench
==================================

# rxll_frame_fifo

Parametrised LocalLink receive frame FIFO in the `rd_clk` domain, behind the SATA link-layer receive path and ahead of the AHCI DMA engine. It buffers `C_DW`-bit words tagged with SOF/EOF/ERR flags, and keeps a committed-frame count instead of a single EOF-ready flag. A store-and-forward mode lets it drop errored or overflowed frames before the reader sees them.

## Interface
- `C_DW`, 32: data width.
- `C_AW`, 9: address width; depth = 2^`C_AW` words.
- `C_STORE_FWD`, 1: 1 = store-and-forward (reader sees committed frames only); 0 = cut-through.
- `C_AF_MARGIN`, 8: `wr_almost_full` asserts when free words ≤ `C_AF_MARGIN`.

Ports:
- `rd_clk` in 1: block clock; both write and read sides use it.
- `rst` in 1: synchronous, active-high reset on `rd_clk`.
- `wr_di` in `C_DW`: write data.
- `wr_sof` in 1: first word of a frame.
- `wr_eof` in 1: last word of a frame.
- `wr_err` in 1: frame error, sampled with `wr_eof`.
- `wr_en` in 1: write strobe.
- `wr_full` out 1: no free word.
- `wr_almost_full` out 1: see `C_AF_MARGIN`.
- `wr_count` out `C_AW`+1: words occupied (`wp` − `rp`).
- `rd_do` out `C_DW`: read data (first-word fall-through).
- `rd_sof` out 1: SOF flag of the `rd_do` word.
- `rd_eof` out 1: EOF flag of the `rd_do` word.
- `rd_err` out 1: ERR flag of the `rd_do` word; can only be set in cut-through mode.
- `rd_valid` out 1: `rd_do` holds a readable word.
- `rd_en` in 1: pop the current word.
- `rd_count` out `C_AW`+1: readable words not yet popped, including the `rd_do` word.
- `rd_eof_rdy` out 1: `frame_count` ≠ 0.
- `frame_count` out `C_AW`+1: complete frames held.
- `drop_count` out 8: frames dropped; saturates at 255.
- `proto_err` out 1: one-cycle pulse on a framing violation.

## Operation
- Memory is 2^`C_AW` × (`C_DW`+3) bits and stores {err, eof, sof, data}.
- Pointers:
  - `wp` = write pointer, `cp` = committed pointer, `rp` = read pointer.
  - All pointers are `C_AW`+1 bits; the MSB distinguishes full from empty.
- `wr_full` = (`wp` − `rp` == 2^`C_AW`).
- A frame is open between an accepted SOF word and its EOF word.
- Accepted write: `wr_en` & !`wr_full` & (frame open | `wr_sof`).
  - Store the word at `wp`, then `wp`++.
  - Cut-through mode: `cp` follows `wp` on every accepted word.
- Store-and-forward, EOF write:
  - If `wr_err` = 0 and the frame is not marked bad: `cp` ← `wp`+1 (commit), `frame_count`++.
  - If `wr_err` = 1 or the frame is marked bad: `wp` ← `cp` (discard the frame), `drop_count`++.
- Cut-through, EOF write: `frame_count`++ always; `wr_err` is stored in the ERR bit of that word.
- Write while `wr_full` with a frame open:
  - The word is not stored.
  - Store-and-forward: the frame is marked bad and is dropped at its EOF.
  - Cut-through: `proto_err` pulses.
- `wr_sof` while a frame is open:
  - `proto_err` pulses.
  - Store-and-forward: the open frame is discarded (`wp` ← `cp`, `drop_count`++) and the new SOF word is written at `cp`.
  - Cut-through: the word is written, and the new frame starts.
- A word with SOF and EOF both set is a single-word frame.
- `wr_en` with no frame open and no `wr_sof`: the word is ignored and `proto_err` pulses.
- Read side:
  - Readable region is [`rp`, `cp`).
  - An output register prefetches the word at `rp`.
  - A pop is `rd_en` & `rd_valid`: `rp`++, and the next word loads on the same edge if one is available.
  - A pop where `rd_eof` = 1 also does `frame_count`−−.
  - `rd_en` with `rd_valid` = 0 is ignored.
- Same-edge increment and decrement of `frame_count` gives no net change.
- `frame_count` cannot overflow, because every frame is at least 1 word.

## Timing
- Reset:
  - Pointers, `frame_count`, `drop_count`, `rd_valid`, `proto_err` and the frame-open/bad state all clear to 0.
  - `rd_do`, `rd_sof`, `rd_eof`, `rd_err` clear to 0.
  - `wr_full` = 0; `wr_almost_full` = 0 for `C_AF_MARGIN` < 2^`C_AW`.
- Reset in mid-frame or mid-read flushes everything. The next word written must carry `wr_sof`.
- Latency from write edge E to `rd_valid` after edge E+1:
  - Cut-through: word written at E.
  - Store-and-forward: the EOF commit happens at E, and the frame's first word is valid after E+1.
- Throughput: 1 word per cycle on each side, simultaneous read and write allowed.
- `wr_count`, `wr_full`, `wr_almost_full` and `rd_count` are registered and update on the edge after the pointer change.
- `drop_count` and `frame_count` update on the same edge as the causing write or pop.
- `rd_eof_rdy` is derived combinationally from `frame_count`.

## Test plan
- **Store-and-forward, 4-word frame:** write words A0..A3 (SOF on A0, EOF on A3) back-to-back.
  - `rd_valid` stays 0 until after the A3 edge +1.
  - Then `frame_count` = 1 and `rd_eof_rdy` = 1.
  - Popping every cycle yields A0..A3, with `rd_eof` on A3, and `frame_count` returns to 0.
- **Store-and-forward error drop:** write 3 words, the third with EOF and `wr_err` = 1.
  - `drop_count` = 1; `wr_count`, `rd_count` and `rd_valid` stay 0.
  - A following good frame is read out intact.
- **Overflow, `C_AW` = 4, store-and-forward:** write a 20-word frame.
  - `wr_full` = 1 after 16 words.
  - At EOF the frame is dropped, `drop_count` = 1 and `wr_count` = 0.
- **Cut-through:** write word B0 with SOF.
  - `rd_valid` = 1 after the next edge.
  - An EOF with `wr_err` = 1 reads out with `rd_err` = 1.
- **Framing violations:** SOF arrives mid-frame → `proto_err` pulses, `drop_count`++, and the new frame survives. A word written without SOF while no frame is open → ignored, and `proto_err` pulses.
- **Simultaneous commit and pop:** commit frame 2 on the same edge that the EOF of frame 1 is popped → `frame_count` holds at 1. Assert `rst` mid-frame → all outputs return to 0 on the next edge.

Source files
------------

// File: rtl/rxll_frame_fifo.sv
`default_nettype none
// ============================================================================
// rxll_frame_fifo : LocalLink receive frame FIFO with committed-frame counting
//                   and optional store-and-forward frame dropping.
// Revision        : 1.0
// ============================================================================
module rxll_frame_fifo #(
  parameter int C_DW        = 32,
  parameter int C_AW        = 9,
  parameter int C_STORE_FWD = 1,
  parameter int C_AF_MARGIN = 8
) (
  input  logic            rd_clk,
  input  logic            rst,
  input  logic [C_DW-1:0] wr_di,
  input  logic            wr_sof,
  input  logic            wr_eof,
  input  logic            wr_err,
  input  logic            wr_en,
  output logic            wr_full,
  output logic            wr_almost_full,
  output logic [C_AW:0]   wr_count,
  output logic [C_DW-1:0] rd_do,
  output logic            rd_sof,
  output logic            rd_eof,
  output logic            rd_err,
  output logic            rd_valid,
  input  logic            rd_en,
  output logic [C_AW:0]   rd_count,
  output logic            rd_eof_rdy,
  output logic [C_AW:0]   frame_count,
  output logic [7:0]      drop_count,
  output logic            proto_err
);

  localparam int            C_MW      = C_DW + 3;
  localparam int            C_DEPTH_I = 1 << C_AW;
  localparam logic [C_AW:0] C_DEPTH   = {1'b1, {C_AW{1'b0}}};
  localparam logic [C_AW:0] C_ONE     = {{C_AW{1'b0}}, 1'b1};
  localparam logic          C_SF      = (C_STORE_FWD != 0);

  // Word layout: {err, eof, sof, data}
  logic [C_MW-1:0] mem [C_DEPTH_I];

  logic [C_AW:0]   wp_q, wp_d, cp_q, cp_d, rp_q, rp_d;
  logic            open_q, open_d, bad_q, bad_d;
  logic [C_AW:0]   frame_count_q, frame_count_d;
  logic [7:0]      drop_count_q, drop_count_d;
  logic            proto_err_q, proto_err_d;
  logic [C_MW-1:0] rd_word_q, rd_word_d;
  logic            rd_valid_q, rd_valid_d;
  logic [C_AW:0]   wr_count_q, wr_count_d, rd_count_q, rd_count_d;
  logic            wr_full_q, wr_full_d, wr_af_q, wr_af_d;

  logic            w_sof_mid, w_stray, w_valid, w_restart, w_store, w_bad;
  logic [C_AW:0]   w_base;
  logic            mem_we;
  logic [C_AW-1:0] mem_waddr;
  logic [C_MW-1:0] mem_wdata;
  logic            fc_inc, fc_dec, w_pop;
  logic [1:0]      drop_inc;
  logic [8:0]      w_drop_sum;
  logic [C_AW:0]   w_used, w_free;

  // Write side. A mid-frame SOF in store-and-forward rewinds to cp, so the
  // replacement word lands at cp and fullness is judged from there.
  always_comb begin
    w_sof_mid   = wr_en & wr_sof & open_q;
    w_stray     = wr_en & ~wr_sof & ~open_q;
    w_valid     = wr_en & (open_q | wr_sof);
    w_restart   = C_SF & w_sof_mid;
    w_base      = w_restart ? cp_q : wp_q;
    w_store     = w_valid & ((w_base - rp_q) != C_DEPTH);
    w_bad       = (bad_q & ~wr_sof) | ~w_store;
    mem_we      = w_store;
    mem_waddr   = w_base[C_AW-1:0];
    mem_wdata   = {~C_SF & wr_eof & wr_err, wr_eof, wr_sof, wr_di};
    wp_d        = wp_q;
    cp_d        = cp_q;
    open_d      = open_q;
    bad_d       = bad_q;
    proto_err_d = w_stray | w_sof_mid;
    fc_inc      = 1'b0;
    drop_inc    = 2'd0;
    if (w_valid) begin
      open_d = ~wr_eof;
      bad_d  = w_bad & ~wr_eof;
      if (w_restart) begin
        wp_d     = cp_q;
        drop_inc = 2'd1;
      end
      if (w_store) begin
        wp_d = w_base + C_ONE;
      end else if (!C_SF) begin
        proto_err_d = 1'b1;
      end
      if (C_SF) begin
        if (wr_eof) begin
          if (wr_err | w_bad) begin
            wp_d     = cp_q;
            drop_inc = drop_inc + 2'd1;
          end else begin
            cp_d   = w_base + C_ONE;
            fc_inc = 1'b1;
          end
        end
      end else if (w_store) begin
        cp_d   = w_base + C_ONE;
        fc_inc = wr_eof;
      end
    end
  end

  // Read side: first-word fall-through register refilled from rp on a pop.
  always_comb begin
    w_pop      = rd_en & rd_valid_q;
    rp_d       = rp_q + (w_pop ? C_ONE : '0);
    fc_dec     = w_pop & rd_word_q[C_DW+1];
    rd_valid_d = rd_valid_q;
    rd_word_d  = rd_word_q;
    if (w_pop || !rd_valid_q) begin
      rd_valid_d = (rp_d != cp_q);
      if (rp_d != cp_q) begin
        rd_word_d = mem[rp_d[C_AW-1:0]];
      end
    end
  end

  always_comb begin
    frame_count_d = frame_count_q + {{C_AW{1'b0}}, fc_inc} - {{C_AW{1'b0}}, fc_dec};
    w_drop_sum    = {1'b0, drop_count_q} + {7'd0, drop_inc};
    drop_count_d  = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    w_used        = wp_q - rp_q;
    w_free        = C_DEPTH - w_used;
    wr_count_d    = w_used;
    wr_full_d     = (w_used == C_DEPTH);
    wr_af_d       = (32'(w_free) <= $unsigned(C_AF_MARGIN));
    rd_count_d    = cp_q - rp_q;
  end

  always_ff @(posedge rd_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      wp_q          <= '0;
      cp_q          <= '0;
      rp_q          <= '0;
      open_q        <= 1'b0;
      bad_q         <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      proto_err_q   <= 1'b0;
      rd_word_q     <= '0;
      rd_valid_q    <= 1'b0;
      wr_count_q    <= '0;
      rd_count_q    <= '0;
      wr_full_q     <= 1'b0;
      wr_af_q       <= 1'b0;
    end else begin
      wp_q          <= wp_d;
      cp_q          <= cp_d;
      rp_q          <= rp_d;
      open_q        <= open_d;
      bad_q         <= bad_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      proto_err_q   <= proto_err_d;
      rd_word_q     <= rd_word_d;
      rd_valid_q    <= rd_valid_d;
      wr_count_q    <= wr_count_d;
      rd_count_q    <= rd_count_d;
      wr_full_q     <= wr_full_d;
      wr_af_q       <= wr_af_d;
    end
  end

  assign wr_full        = wr_full_q;
  assign wr_almost_full = wr_af_q;
  assign wr_count       = wr_count_q;
  assign rd_do          = rd_word_q[C_DW-1:0];
  assign rd_sof         = rd_word_q[C_DW];
  assign rd_eof         = rd_word_q[C_DW+1];
  assign rd_err         = rd_word_q[C_DW+2];
  assign rd_valid       = rd_valid_q;
  assign rd_count       = rd_count_q;
  assign rd_eof_rdy     = (frame_count_q != '0);
  assign frame_count    = frame_count_q;
  assign drop_count     = drop_count_q;
  assign proto_err      = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rxll_frame_fifo.sv
`default_nettype none
// ============================================================================
// tb_rxll_frame_fifo : directed bench with a queue scoreboard for one
//                      store-and-forward (index 0) and one cut-through (index 1) FIFO.
// Revision           : 1.0
// ============================================================================
module tb_rxll_frame_fifo;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          rd_clk = 1'b0;
  logic          rst;
  logic [DW-1:0] wr_di [2];
  logic          wr_sof [2], wr_eof [2], wr_err [2], wr_en [2], rd_en [2];
  logic          wr_full [2], wr_almost_full [2], rd_sof [2], rd_eof [2], rd_err [2];
  logic          rd_valid [2], rd_eof_rdy [2], proto_err [2];
  logic [DW-1:0] rd_do [2];
  logic [AW:0]   wr_count [2], rd_count [2], frame_count [2];
  logic [7:0]    drop_count [2];

  logic [DW+2:0] q0 [$];
  logic [DW+2:0] q1 [$];
  int total = 0;
  int bad   = 0;

  always #5 rd_clk = ~rd_clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rxll_frame_fifo #(
      .C_DW(DW), .C_AW(AW), .C_STORE_FWD(g == 0 ? 1 : 0), .C_AF_MARGIN(8)
    ) u_dut (
      .rd_clk(rd_clk), .rst(rst),
      .wr_di(wr_di[g]), .wr_sof(wr_sof[g]), .wr_eof(wr_eof[g]), .wr_err(wr_err[g]),
      .wr_en(wr_en[g]), .wr_full(wr_full[g]), .wr_almost_full(wr_almost_full[g]),
      .wr_count(wr_count[g]), .rd_do(rd_do[g]), .rd_sof(rd_sof[g]), .rd_eof(rd_eof[g]),
      .rd_err(rd_err[g]), .rd_valid(rd_valid[g]), .rd_en(rd_en[g]),
      .rd_count(rd_count[g]), .rd_eof_rdy(rd_eof_rdy[g]),
      .frame_count(frame_count[g]), .drop_count(drop_count[g]), .proto_err(proto_err[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // keep != 0: the word belongs to a frame the reader must eventually see
  task automatic wr(input int d, input logic [31:0] data, input int sof, input int eof,
                    input int err, input int keep);
    logic [DW+2:0] v;
    v = {(d == 1) && (eof != 0) && (err != 0), eof != 0, sof != 0, data};
    if (keep != 0) begin
      if (d == 0) q0.push_back(v);
      else        q1.push_back(v);
    end
    wr_di[d]  = data;
    wr_sof[d] = (sof != 0);
    wr_eof[d] = (eof != 0);
    wr_err[d] = (err != 0);
    wr_en[d]  = 1'b1;
    step();
    wr_en[d]  = 1'b0;
    wr_sof[d] = 1'b0;
    wr_eof[d] = 1'b0;
    wr_err[d] = 1'b0;
  endtask

  // Scoreboard monitors: a pop happens on the next edge whenever valid & en
  always @(negedge rd_clk) begin
    if (!rst && rd_valid[0] && rd_en[0]) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sf_extra_word: actual=%0h required=none", rd_do[0]);
      end else begin
        chk("sf_word", 64'({rd_err[0], rd_eof[0], rd_sof[0], rd_do[0]}), 64'(q0.pop_front()));
      end
    end
  end

  always @(negedge rd_clk) begin
    if (!rst && rd_valid[1] && rd_en[1]) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ct_extra_word: actual=%0h required=none", rd_do[1]);
      end else begin
        chk("ct_word", 64'({rd_err[1], rd_eof[1], rd_sof[1], rd_do[1]}), 64'(q1.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      wr_di[i] = '0; wr_sof[i] = 1'b0; wr_eof[i] = 1'b0; wr_err[i] = 1'b0;
      wr_en[i] = 1'b0; rd_en[i] = 1'b1;
    end
    rst = 1'b1;
    idle(2);
    rst = 1'b0;

    // Reset state
    chk("rst_rd_valid", 64'(rd_valid[0]), 64'd0);
    chk("rst_wr_count", 64'(wr_count[0]), 64'd0);
    chk("rst_wr_full", 64'(wr_full[0]), 64'd0);
    chk("rst_almost_full", 64'(wr_almost_full[0]), 64'd0);
    chk("rst_frame_count", 64'(frame_count[0]), 64'd0);
    chk("rst_drop_count", 64'(drop_count[0]), 64'd0);

    // Store-and-forward 4-word frame
    wr(0, 32'hA0, 1, 0, 0, 1); chk("sf_hold_a0", 64'(rd_valid[0]), 64'd0);
    wr(0, 32'hA1, 0, 0, 0, 1); chk("sf_hold_a1", 64'(rd_valid[0]), 64'd0);
    wr(0, 32'hA2, 0, 0, 0, 1); chk("sf_hold_a2", 64'(rd_valid[0]), 64'd0);
    wr(0, 32'hA3, 0, 1, 0, 1);
    chk("sf_hold_a3", 64'(rd_valid[0]), 64'd0);
    chk("sf_commit_fc", 64'(frame_count[0]), 64'd1);
    chk("sf_eof_rdy", 64'(rd_eof_rdy[0]), 64'd1);
    step();
    chk("sf_valid", 64'(rd_valid[0]), 64'd1);
    chk("sf_wr_count", 64'(wr_count[0]), 64'd4);
    chk("sf_rd_count", 64'(rd_count[0]), 64'd4);
    idle(4);
    chk("sf_drained_fc", 64'(frame_count[0]), 64'd0);
    chk("sf_drained_valid", 64'(rd_valid[0]), 64'd0);

    // Store-and-forward errored frame is dropped
    wr(0, 32'hE0, 1, 0, 0, 0);
    wr(0, 32'hE1, 0, 0, 0, 0);
    wr(0, 32'hE2, 0, 1, 1, 0);
    chk("err_drop_count", 64'(drop_count[0]), 64'd1);
    idle(2);
    chk("err_wr_count", 64'(wr_count[0]), 64'd0);
    chk("err_rd_count", 64'(rd_count[0]), 64'd0);
    chk("err_rd_valid", 64'(rd_valid[0]), 64'd0);
    wr(0, 32'h60, 1, 0, 0, 1);
    wr(0, 32'h61, 0, 1, 0, 1);
    idle(4);

    // Overflow: a 20-word frame into 16 words of storage
    for (int i = 0; i < 20; i++) begin
      wr(0, 32'h100 + 32'(i), (i == 0) ? 1 : 0, (i == 19) ? 1 : 0, 0, 0);
      if (i == 8) begin
        chk("ovf_wr_count8", 64'(wr_count[0]), 64'd8);
        chk("ovf_almost_full", 64'(wr_almost_full[0]), 64'd1);
      end
      if (i == 16) chk("ovf_wr_full", 64'(wr_full[0]), 64'd1);
    end
    chk("ovf_drop_count", 64'(drop_count[0]), 64'd2);
    idle(1);
    chk("ovf_wr_count0", 64'(wr_count[0]), 64'd0);
    chk("ovf_full_clear", 64'(wr_full[0]), 64'd0);
    wr(0, 32'hC0, 1, 1, 0, 1);
    idle(3);

    // Framing violations in store-and-forward
    wr(0, 32'hD0, 1, 0, 0, 0);
    wr(0, 32'hD1, 0, 0, 0, 0);
    wr(0, 32'hD8, 1, 0, 0, 1);
    chk("sof_mid_proto", 64'(proto_err[0]), 64'd1);
    chk("sof_mid_drop", 64'(drop_count[0]), 64'd3);
    wr(0, 32'hD9, 0, 1, 0, 1);
    chk("proto_pulse_end", 64'(proto_err[0]), 64'd0);
    wr(0, 32'hEE, 0, 0, 0, 0);
    chk("stray_proto", 64'(proto_err[0]), 64'd1);
    idle(4);
    chk("stray_ignored", 64'(wr_count[0]), 64'd0);

    // Commit of frame 2 on the same edge as the EOF pop of frame 1
    rd_en[0] = 1'b0;
    wr(0, 32'hF10, 1, 0, 0, 1);
    wr(0, 32'hF11, 0, 1, 0, 1);
    wr(0, 32'hF20, 1, 0, 0, 1);
    chk("same_edge_valid", 64'(rd_valid[0]), 64'd1);
    chk("same_edge_fc_pre", 64'(frame_count[0]), 64'd1);
    rd_en[0] = 1'b1;
    step();
    wr(0, 32'hF21, 0, 1, 0, 1);
    chk("same_edge_fc", 64'(frame_count[0]), 64'd1);
    idle(3);
    chk("same_edge_fc_end", 64'(frame_count[0]), 64'd0);

    // Cut-through
    wr(1, 32'hB0, 1, 0, 0, 1);
    chk("ct_latency0", 64'(rd_valid[1]), 64'd0);
    wr(1, 32'hB1, 0, 0, 0, 1);
    chk("ct_latency1", 64'(rd_valid[1]), 64'd1);
    wr(1, 32'hB2, 0, 1, 1, 1);
    chk("ct_fc", 64'(frame_count[1]), 64'd1);
    idle(3);
    chk("ct_fc_end", 64'(frame_count[1]), 64'd0);
    chk("ct_valid_end", 64'(rd_valid[1]), 64'd0);
    wr(1, 32'hEF, 0, 0, 0, 0);
    chk("ct_stray_proto", 64'(proto_err[1]), 64'd1);

    // Reset mid-frame and mid-read
    rd_en[1] = 1'b0;
    wr(1, 32'h70, 1, 0, 0, 0);
    wr(1, 32'h71, 0, 0, 0, 0);
    wr(0, 32'h72, 1, 0, 0, 0);
    chk("pre_rst_ct_valid", 64'(rd_valid[1]), 64'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 64'(rd_valid[1]), 64'd0);
    chk("mid_rst_do", 64'(rd_do[1]), 64'd0);
    chk("mid_rst_sof", 64'(rd_sof[1]), 64'd0);
    chk("mid_rst_wr_count", 64'(wr_count[1]), 64'd0);
    chk("mid_rst_drop", 64'(drop_count[0]), 64'd0);
    chk("mid_rst_fc", 64'(frame_count[1]), 64'd0);
    rst = 1'b0;
    rd_en[1] = 1'b1;
    wr(0, 32'h73, 0, 1, 0, 0);
    chk("post_rst_need_sof", 64'(proto_err[0]), 64'd1);
    idle(2);
    chk("post_rst_wr_count", 64'(wr_count[0]), 64'd0);
    chk("post_rst_valid", 64'(rd_valid[0]), 64'd0);

    for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) step();
    chk("sf_queue_empty", 64'(q0.size()), 64'd0);
    chk("ct_queue_empty", 64'(q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
